// File: rtl/rr_prio_arbiter_lzc.sv
`default_nettype none
// ============================================================================
// Module   : rr_prio_arbiter_lzc
// Brief    : Trailing-zero counter; returns the lowest set bit index and an
//            empty flag when no bit is set.
// Revision : 1.0 - initial release
// ============================================================================
module rr_prio_arbiter_lzc #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        cnt_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                cnt_o = CNT_WIDTH'(i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule
`default_nettype wire

// File: rtl/rr_prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_prio_arbiter
// Brief    : N-way valid/ready arbiter, runtime fixed-priority or round-robin,
//            with optional decision lock-in until the handshake completes.
// Revision : 1.0 - initial release
// ============================================================================
module rr_prio_arbiter #(
    parameter int unsigned NumIn     = 4,
    parameter int unsigned DataWidth = 32,
    parameter bit          LockIn    = 1'b1,
    parameter int unsigned IdxWidth  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             flush_i,
    input  logic                             rr_mode_i,
    input  logic [NumIn-1:0]                 req_i,
    input  logic [NumIn-1:0][DataWidth-1:0]  data_i,
    output logic [NumIn-1:0]                 gnt_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [DataWidth-1:0]             data_o,
    output logic [IdxWidth-1:0]              idx_o
);

    typedef logic [IdxWidth-1:0] idx_t;
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    idx_t             rr_ptr_q;
    logic [NumIn-1:0] w_mask;
    logic [NumIn-1:0] w_req_masked;
    idx_t             w_cnt_all;
    idx_t             w_cnt_masked;
    logic             w_empty_all;
    logic             w_empty_masked;
    idx_t             w_sel_idx;
    logic             w_locked;
    idx_t             w_lock_idx;
    logic             w_handshake;

    // Ports at or above the round-robin pointer are eligible first.
    for (genvar i = 0; i < NumIn; i++) begin : g_mask
        assign w_mask[i] = ({1'b0, rr_ptr_q} <= (IdxWidth + 1)'(i));
    end
    assign w_req_masked = req_i & w_mask;

    rr_prio_arbiter_lzc #(
        .WIDTH     (NumIn),
        .CNT_WIDTH (IdxWidth)
    ) u_lzc_all (
        .in_i    (req_i),
        .cnt_o   (w_cnt_all),
        .empty_o (w_empty_all)
    );

    rr_prio_arbiter_lzc #(
        .WIDTH     (NumIn),
        .CNT_WIDTH (IdxWidth)
    ) u_lzc_masked (
        .in_i    (w_req_masked),
        .cnt_o   (w_cnt_masked),
        .empty_o (w_empty_masked)
    );

    assign w_sel_idx   = (rr_mode_i && !w_empty_masked) ? w_cnt_masked : w_cnt_all;
    assign idx_o       = w_locked ? w_lock_idx : w_sel_idx;
    assign valid_o     = w_locked | ~w_empty_all;
    assign data_o      = data_i[idx_o];
    assign w_handshake = valid_o & ready_i;

    always_comb begin
        gnt_o = '0;
        if (w_handshake) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

    if (NumIn > 1) begin : g_rr_ptr
        idx_t                rr_ptr_d;
        logic [IdxWidth:0]   w_ptr_inc;

        // Widened add so a non-power-of-two NumIn wraps correctly.
        assign w_ptr_inc = {1'b0, idx_o} + (IdxWidth + 1)'(1);

        always_comb begin
            rr_ptr_d = rr_ptr_q;
            if (flush_i) begin
                rr_ptr_d = '0;
            end else if (w_handshake && rr_mode_i) begin
                rr_ptr_d = (w_ptr_inc >= (IdxWidth + 1)'(NumIn)) ? '0 : w_ptr_inc[IdxWidth-1:0];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rr_ptr_q <= '0;
            end else begin
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end else begin : g_rr_ptr_const
        assign rr_ptr_q = '0;
    end

    if (LockIn) begin : g_lock
        lock_state_e state_q, state_d;
        idx_t        idx_q, idx_d;

        always_comb begin
            state_d = state_q;
            idx_d   = idx_q;
            case (state_q)
                IDLE: begin
                    if (valid_o && !ready_i && !flush_i) begin
                        state_d = LOCKED;
                        idx_d   = idx_o;
                    end
                end
                LOCKED: begin
                    if (w_handshake || flush_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= IDLE;
                idx_q   <= '0;
            end else begin
                state_q <= state_d;
                idx_q   <= idx_d;
            end
        end

        assign w_locked   = (state_q == LOCKED);
        assign w_lock_idx = idx_q;

`ifndef SYNTHESIS
        // A locked requestor must hold its request and payload until granted.
        a_lock_req_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
            w_locked |-> req_i[idx_q]);
        a_lock_data_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (w_locked && $past(w_locked)) |-> (data_i[idx_q] == $past(data_i[idx_q])));
`endif
    end else begin : g_no_lock
        assign w_locked   = 1'b0;
        assign w_lock_idx = '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_prio_arbiter
// Brief    : Directed self-checking bench for rr_prio_arbiter (lock-in and
//            non-lock-in instances, NumIn=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_prio_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic               rr_mode;
    logic [N-1:0]       req;
    logic [N-1:0][DW-1:0] data;
    logic [N-1:0]       gnt;
    logic               valid;
    logic               ready;
    logic [DW-1:0]      dout;
    logic [1:0]         idx;

    logic [N-1:0]       req_b;
    logic [N-1:0]       gnt_b;
    logic               valid_b;
    logic [DW-1:0]      dout_b;
    logic [1:0]         idx_b;

    int total;
    int passed;

    rr_prio_arbiter #(.NumIn(N), .DataWidth(DW), .LockIn(1'b1)) u_dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .flush_i   (flush),
        .rr_mode_i (rr_mode),
        .req_i     (req),
        .data_i    (data),
        .gnt_o     (gnt),
        .valid_o   (valid),
        .ready_i   (ready),
        .data_o    (dout),
        .idx_o     (idx)
    );

    rr_prio_arbiter #(.NumIn(N), .DataWidth(DW), .LockIn(1'b0)) u_dut_nolock (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .flush_i   (1'b0),
        .rr_mode_i (1'b0),
        .req_i     (req_b),
        .data_i    (data),
        .gnt_o     (gnt_b),
        .valid_o   (valid_b),
        .ready_i   (1'b0),
        .data_o    (dout_b),
        .idx_o     (idx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        rr_mode = 1'b0;
        req     = '0;
        req_b   = '0;
        ready   = 1'b0;
        data    = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

        @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_gnt",   32'(gnt),   32'd0);
        chk("rst_idx",   32'(idx),   32'd0);
        chk("rst_data",  dout,       32'hD0);
        tick();
        rst_n = 1'b1;

        // Fixed priority, lowest index wins
        req = 4'b1010; ready = 1'b1;
        @(negedge clk);
        chk("fix_valid", 32'(valid), 32'd1);
        chk("fix_idx",   32'(idx),   32'd1);
        chk("fix_gnt",   32'(gnt),   32'b0010);
        chk("fix_data",  dout,       32'hD1);
        tick();

        // Stall on port 3, lock holds, then port 0 joins
        req = 4'b1000; ready = 1'b0;
        @(negedge clk);
        chk("stall0_idx", 32'(idx), 32'd3);
        chk("stall0_gnt", 32'(gnt), 32'd0);
        tick();
        @(negedge clk);
        chk("stall1_idx", 32'(idx), 32'd3);
        tick();
        @(negedge clk);
        chk("stall2_valid", 32'(valid), 32'd1);
        tick();
        req = 4'b1001; ready = 1'b1;
        @(negedge clk);
        chk("stall_rel_idx",  32'(idx), 32'd3);
        chk("stall_rel_gnt",  32'(gnt), 32'b1000);
        chk("stall_rel_data", dout,     32'hD3);
        tick();
        @(negedge clk);
        chk("after_rel_idx", 32'(idx), 32'd0);
        chk("after_rel_gnt", 32'(gnt), 32'b0001);
        tick();

        // Round robin, all requesting: 0,1,2,3,0
        rr_mode = 1'b1; req = 4'b1111; ready = 1'b1;
        @(negedge clk); chk("rr_g0", 32'(gnt), 32'b0001); tick();
        @(negedge clk); chk("rr_g1", 32'(gnt), 32'b0010); tick();
        @(negedge clk); chk("rr_g2", 32'(gnt), 32'b0100); tick();
        @(negedge clk); chk("rr_g3", 32'(gnt), 32'b1000); tick();
        @(negedge clk); chk("rr_g4", 32'(gnt), 32'b0001); tick();

        // Pointer now 1; grant port 2 to move pointer to 3, then wrap
        req = 4'b0100;
        @(negedge clk); chk("rr_p2", 32'(idx), 32'd2); tick();
        req = 4'b0011;
        @(negedge clk);
        chk("rr_wrap_idx", 32'(idx), 32'd0);
        chk("rr_wrap_gnt", 32'(gnt), 32'b0001);
        tick();
        @(negedge clk);
        chk("rr_ptr1_idx", 32'(idx), 32'd1);
        tick();

        // Pointer 2; lock port 2, mode switch ignored while locked, then flush+ready
        req = 4'b0100; ready = 1'b0;
        @(negedge clk); chk("lk2_idx", 32'(idx), 32'd2); tick();
        rr_mode = 1'b0; req = 4'b0101;
        @(negedge clk); chk("lk2_hold_idx", 32'(idx), 32'd2); tick();
        flush = 1'b1; ready = 1'b1;
        @(negedge clk); chk("flush_gnt", 32'(gnt), 32'b0100); tick();
        flush = 1'b0; rr_mode = 1'b1; req = 4'b1001;
        @(negedge clk);
        chk("flush_ptr0_idx", 32'(idx), 32'd0);
        chk("flush_ptr0_gnt", 32'(gnt), 32'b0001);
        tick();

        // Flush without ready must drop the lock
        req = 4'b0100; ready = 1'b0;
        @(negedge clk); chk("lk2b_idx", 32'(idx), 32'd2); tick();
        flush = 1'b1;
        @(negedge clk); chk("flush_nr_gnt", 32'(gnt), 32'd0); tick();
        flush = 1'b0; rr_mode = 1'b0; req = 4'b0011;
        @(negedge clk); chk("unlocked_idx", 32'(idx), 32'd0); tick();
        ready = 1'b1;
        @(negedge clk); chk("lk0_gnt", 32'(gnt), 32'b0001); tick();

        // No lock-in variant follows requests during stall
        req_b = 4'b0100; req = 4'b0000; ready = 1'b0;
        @(negedge clk);
        chk("nl_idx2", 32'(idx_b), 32'd2);
        chk("nl_gnt2", 32'(gnt_b), 32'd0);
        tick();
        req_b = 4'b0001;
        @(negedge clk);
        chk("nl_idx0",   32'(idx_b),   32'd0);
        chk("nl_gnt0",   32'(gnt_b),   32'd0);
        chk("nl_valid0", 32'(valid_b), 32'd1);
        chk("nl_data0",  dout_b,       32'hD0);
        tick();

        // Async reset mid-stall drops the lock without a clock edge
        req = 4'b1000; ready = 1'b0;
        @(negedge clk); chk("pre_rst_idx", 32'(idx), 32'd3); tick();
        rst_n = 1'b0; req = 4'b0001;
        #1;
        chk("arst_idx", 32'(idx), 32'd0);
        chk("arst_gnt", 32'(gnt), 32'd0);
        tick();
        rst_n = 1'b1;
        req   = 4'b0000;
        @(negedge clk);
        chk("post_rst_valid", 32'(valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
